mips_exec_decode_core: RTL and testbench

- Combines the MIPS main control decoder, the ALU-control decoder and the 32-bit ALU into one block for the 5-stage pipeline.
- Main decode is combinational from the ID-stage opcode and drives the ID/EX control bundle.
- The ALU path is combinational from EX-stage operands and controls, with its result and equal flag also registered for the EX/MEM boundary.

---
 rtl/mips_exec_decode_core_pkg.sv | 47 ++++
 rtl/mips_exec_decode_core_alu.sv | 41 ++++
 rtl/mips_exec_decode_core.sv | 102 ++++++++++
 tb/tb_mips_exec_decode_core.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_exec_decode_core_pkg.sv
// Shared MIPS decode constants: opcodes, funct codes, ALU class codes and
// the 4-bit ALU operation encodings used by the decoder and the ALU core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SLL     = 4'b0011;
  localparam logic [3:0] ALU_SRL     = 4'b0100;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_NOR     = 4'b1100;
  localparam logic [3:0] ALU_INVALID = 4'b1111;

  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/mips_exec_decode_core_alu.sv
// Combinational 32-bit MIPS ALU with an operation-independent equality flag.
module mips_alu_core
  import mips_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [3:0]         alu_ctrl,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  output logic [WIDTH-1:0]   alu_result,
  output logic               equal_flag
);

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic                    less_s;

  assign a_s        = operand_a;
  assign b_s        = operand_b;
  assign less_s     = (a_s < b_s);
  assign equal_flag = (operand_a == operand_b);

  // Shifts operate on operand_b, matching the MIPS rt-is-shifted convention.
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_ADD: alu_result = operand_a + operand_b;
      ALU_SUB: alu_result = operand_a - operand_b;
      ALU_AND: alu_result = operand_a & operand_b;
      ALU_OR:  alu_result = operand_a | operand_b;
      ALU_NOR: alu_result = ~(operand_a | operand_b);
      ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, less_s};
      ALU_SLL: alu_result = operand_b << shamt;
      ALU_SRL: alu_result = operand_b >> shamt;
      default: alu_result = '0;
    endcase
  end

endmodule

// File: rtl/mips_exec_decode_core.sv
// MIPS main control decode (ID), ALU-control decode and ALU (EX), with the
// ALU result and equal flag registered at the EX/MEM boundary.
module mips_exec_decode_core
  import mips_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  output logic               reg_dst,
  output logic               branch,
  output logic               mem_read,
  output logic               mem_to_reg,
  output logic [1:0]         alu_op,
  output logic               mem_write,
  output logic               alu_src,
  output logic               reg_write,
  input  logic [1:0]         ex_alu_op,
  input  logic [5:0]         funct,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  output logic [3:0]         alu_ctrl,
  output logic [WIDTH-1:0]   alu_result,
  output logic               equal_flag,
  output logic [WIDTH-1:0]   result_q,
  output logic               equal_q
);

  ctrl_t ctrl;

  // Unknown opcodes decode to all-zero so they behave as a pipeline bubble.
  always_comb begin
    ctrl = CTRL_NOP;
    case (opcode)
      OP_RTYPE: ctrl = '{reg_dst: 1'b1, alu_op: ALUOP_FUNCT, reg_write: 1'b1, default: '0};
      OP_LW:    ctrl = '{mem_read: 1'b1, mem_to_reg: 1'b1, alu_op: ALUOP_ADD,
                         alu_src: 1'b1, reg_write: 1'b1, default: '0};
      OP_SW:    ctrl = '{mem_write: 1'b1, alu_src: 1'b1, alu_op: ALUOP_ADD, default: '0};
      OP_BEQ:   ctrl = '{branch: 1'b1, alu_op: ALUOP_SUB, default: '0};
      OP_ADDI:  ctrl = '{alu_src: 1'b1, reg_write: 1'b1, alu_op: ALUOP_ADD, default: '0};
      default:  ctrl = CTRL_NOP;
    endcase
  end

  assign reg_dst    = ctrl.reg_dst;
  assign branch     = ctrl.branch;
  assign mem_read   = ctrl.mem_read;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_op     = ctrl.alu_op;
  assign mem_write  = ctrl.mem_write;
  assign alu_src    = ctrl.alu_src;
  assign reg_write  = ctrl.reg_write;

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (ex_alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_NOR:  alu_ctrl = ALU_NOR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          FN_SLL:  alu_ctrl = ALU_SLL;
          FN_SRL:  alu_ctrl = ALU_SRL;
          default: alu_ctrl = ALU_INVALID;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  mips_alu_core #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_alu (
    .alu_ctrl   (alu_ctrl),
    .shamt      (shamt),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .alu_result (alu_result),
    .equal_flag (equal_flag)
  );

  // EX/MEM boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      equal_q  <= 1'b0;
    end else begin
      result_q <= alu_result;
      equal_q  <= equal_flag;
    end
  end

endmodule

// File: tb/tb_mips_exec_decode_core.sv
// Scoreboard bench for mips_exec_decode_core: decode sweep, ALU vectors,
// registered outputs and asynchronous reset behaviour.
module tb_mips_exec_decode_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic [1:0]  alu_op;
  logic [1:0]  ex_alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] operand_a, operand_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        equal_flag;
  logic [31:0] result_q;
  logic        equal_q;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_exec_decode_core #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .reg_dst    (reg_dst),
    .branch     (branch),
    .mem_read   (mem_read),
    .mem_to_reg (mem_to_reg),
    .alu_op     (alu_op),
    .mem_write  (mem_write),
    .alu_src    (alu_src),
    .reg_write  (reg_write),
    .ex_alu_op  (ex_alu_op),
    .funct      (funct),
    .shamt      (shamt),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .equal_flag (equal_flag),
    .result_q   (result_q),
    .equal_q    (equal_q)
  );

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        eq;
  } alu_vec_t;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        eq;
  } exp_t;

  alu_vec_t vecs[$];
  exp_t     comb_q[$];
  exp_t     reg_q[$];
  logic [5:0] ops[$];
  logic [8:0] op_exp[$];
  logic [8:0] dec_exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl,
                         input logic [31:0] res, input logic eq);
    alu_vec_t v;
    v.op = op; v.fn = fn; v.sh = sh; v.a = a; v.b = b;
    v.ctrl = ctrl; v.res = res; v.eq = eq;
    vecs.push_back(v);
  endtask

  task automatic drive_alu(input alu_vec_t v);
    exp_t e;
    ex_alu_op = v.op; funct = v.fn; shamt = v.sh; operand_a = v.a; operand_b = v.b;
    e.ctrl = v.ctrl; e.res = v.res; e.eq = v.eq;
    comb_q.push_back(e);
    reg_q.push_back(e);
  endtask

  task automatic check_comb(input string tag);
    exp_t e;
    if (comb_q.size() == 0) begin
      check({tag, "_empty_sb"}, 32'd1, 32'd0);
      return;
    end
    e = comb_q.pop_front();
    check({tag, "_ctrl"}, {28'd0, alu_ctrl}, {28'd0, e.ctrl});
    check({tag, "_res"}, alu_result, e.res);
    check({tag, "_eq"}, {31'd0, equal_flag}, {31'd0, e.eq});
  endtask

  task automatic check_reg(input string tag);
    exp_t e;
    if (reg_q.size() == 0) begin
      check({tag, "_empty_sb"}, 32'd1, 32'd0);
      return;
    end
    e = reg_q.pop_front();
    check({tag, "_result_q"}, result_q, e.res);
    check({tag, "_equal_q"}, {31'd0, equal_q}, {31'd0, e.eq});
  endtask

  task automatic reset_sequence(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] sum, input logic eq);
    alu_vec_t v;
    v.op = 2'b00; v.fn = 6'b000000; v.sh = 5'd0; v.a = a; v.b = b;
    v.ctrl = 4'b0010; v.res = sum; v.eq = eq;
    @(negedge clk);
    drive_alu(v);
    #1 check_comb("rst_pre");
    @(posedge clk); #1;
    check_reg("rst_capture");
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_result_q", result_q, 32'd0);
    check("rst_async_equal_q", {31'd0, equal_q}, 32'd0);
    check("rst_comb_unaffected", alu_result, sum);
    @(posedge clk); #1;
    check("rst_hold_result_q", result_q, 32'd0);
    check("rst_hold_equal_q", {31'd0, equal_q}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    reg_q.push_back('{ctrl: 4'b0010, res: sum, eq: eq});
    @(posedge clk); #1;
    check_reg("rst_recapture");
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 6'b111111;
    ex_alu_op = 2'b00; funct = 6'd0; shamt = 5'd0;
    operand_a = 32'd0; operand_b = 32'd0;
    #2;
    check("reset_result_q", result_q, 32'd0);
    check("reset_equal_q", {31'd0, equal_q}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Control vectors: {reg_dst,branch,mem_read,mem_to_reg,alu_op,mem_write,alu_src,reg_write}
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b111111, 6'b000010};
    op_exp = '{9'b1_0_0_0_10_0_0_1, 9'b0_0_1_1_00_0_1_1, 9'b0_0_0_0_00_1_1_0,
               9'b0_1_0_0_01_0_0_0, 9'b0_0_0_0_00_0_1_1, 9'b0, 9'b0};
    for (int i = 0; i < ops.size(); i++) begin
      @(negedge clk);
      opcode = ops[i];
      dec_exp_q.push_back(op_exp[i]);
      #1;
      check($sformatf("decode_op%06b", ops[i]),
            {23'd0, reg_dst, branch, mem_read, mem_to_reg, alu_op, mem_write, alu_src, reg_write},
            {23'd0, dec_exp_q.pop_front()});
    end

    add_vec(2'b10, 6'b100000, 5'd0, 32'd3,          32'd4,          4'b0010, 32'd7,          1'b0);
    add_vec(2'b10, 6'b100000, 5'd0, 32'hFFFF_FFFF,  32'd1,          4'b0010, 32'd0,          1'b0);
    add_vec(2'b10, 6'b100010, 5'd0, 32'd5,          32'd7,          4'b0110, 32'hFFFF_FFFE,  1'b0);
    add_vec(2'b10, 6'b101010, 5'd0, 32'h8000_0000,  32'd1,          4'b0111, 32'd1,          1'b0);
    add_vec(2'b10, 6'b101010, 5'd0, 32'd1,          32'h8000_0000,  4'b0111, 32'd0,          1'b0);
    add_vec(2'b10, 6'b101010, 5'd0, 32'h8000_0000,  32'h7FFF_FFFF,  4'b0111, 32'd1,          1'b0);
    add_vec(2'b10, 6'b100100, 5'd0, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  4'b0000, 32'h00F0_00F0,  1'b0);
    add_vec(2'b10, 6'b100101, 5'd0, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  4'b0001, 32'hFFF0_FFF0,  1'b0);
    add_vec(2'b10, 6'b100111, 5'd0, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  4'b1100, 32'h000F_000F,  1'b0);
    add_vec(2'b10, 6'b000000, 5'd31, 32'd0,         32'd1,          4'b0011, 32'h8000_0000,  1'b0);
    add_vec(2'b10, 6'b000010, 5'd31, 32'd0,         32'h8000_0000,  4'b0100, 32'd1,          1'b0);
    add_vec(2'b10, 6'b000000, 5'd0,  32'd0,         32'hDEAD_BEEF,  4'b0011, 32'hDEAD_BEEF,  1'b0);
    add_vec(2'b10, 6'b000010, 5'd4,  32'd0,         32'hF000_0000,  4'b0100, 32'h0F00_0000,  1'b0);
    add_vec(2'b10, 6'b111111, 5'd0,  32'd5,         32'd5,          4'b1111, 32'd0,          1'b1);
    add_vec(2'b10, 6'b100101, 5'd0,  32'h1234,      32'h1234,       4'b0001, 32'h1234,       1'b1);
    add_vec(2'b10, 6'b100101, 5'd0,  32'h1234,      32'h1235,       4'b0001, 32'h1235,       1'b0);
    add_vec(2'b00, 6'b100010, 5'd0,  32'd10,        32'd3,          4'b0010, 32'd13,         1'b0);
    add_vec(2'b01, 6'b100000, 5'd0,  32'd10,        32'd3,          4'b0110, 32'd7,          1'b0);
    add_vec(2'b11, 6'b100100, 5'd0,  32'd1,         32'd2,          4'b0010, 32'd3,          1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive_alu(vecs[i]);
      #1 check_comb($sformatf("alu_v%0d", i));
      @(posedge clk); #1;
      check_reg($sformatf("reg_v%0d", i));
    end

    reset_sequence(32'd3, 32'd4, 32'd7, 1'b0);
    reset_sequence(32'd9, 32'd9, 32'd18, 1'b1);

    check("sb_drained", comb_q.size() + reg_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
